frame_out_arbiter: RTL and testbench



---
 rtl/frame_out_arbiter.sv | 166 ++++++++++++++++
 tb/tb_frame_out_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_out_arbiter.sv
// Packet-atomic round-robin merge of two word streams onto one registered 32-bit output, optional routing header per packet.
// Grant-to-header two cycles, one word/cycle in a packet; the output register holds data and valid while i_out_rdy is low.
module frame_out_arbiter #(
  parameter int         HDR_EN  = 1,
  parameter logic [7:0] HDR_TAG = 8'hA5
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        i_pend_0,
  input  logic        i_pend_1,
  input  logic [15:0] i_len_0,
  input  logic [15:0] i_len_1,
  input  logic [31:0] i_data_0,
  input  logic [31:0] i_data_1,
  input  logic        i_vld_0,
  input  logic        i_vld_1,
  output logic        o_rdy_0,
  output logic        o_rdy_1,
  output logic        o_done_0,
  output logic        o_done_1,
  output logic [31:0] o_out_data,
  output logic        o_out_vld,
  input  logic        i_out_rdy,
  output logic [1:0]  o_grant,
  output logic        o_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA} state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, cnt_q;
  logic        src_q, last_q;
  logic [31:0] out_data_q;
  logic        out_vld_q;
  logic [1:0]  done_q;

  logic        slot_free, any_pend, sel, src_vld, last_word;
  logic        grant_ev, hdr_load, acc, done_set, done_src;
  logic [15:0] len_sel;
  logic [31:0] src_data;

  assign slot_free = ~out_vld_q | i_out_rdy;
  assign any_pend  = i_pend_0 | i_pend_1;
  // Both pending: serve whoever was not served last; otherwise the lone requester.
  assign sel       = (i_pend_0 & i_pend_1) ? ~last_q : ~i_pend_0;
  assign len_sel   = sel ? i_len_1 : i_len_0;
  assign src_vld   = src_q ? i_vld_1 : i_vld_0;
  assign src_data  = src_q ? i_data_1 : i_data_0;
  assign last_word = (cnt_q == len_q - 16'd1);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_pend) begin
          if (HDR_EN != 0) begin
            state_d = ST_HDR;
          end else if (len_sel != 16'd0) begin
            state_d = ST_DATA;
          end
        end
      end
      ST_HDR: begin
        if (slot_free) begin
          state_d = (len_q != 16'd0) ? ST_DATA : ST_IDLE;
        end
      end
      ST_DATA: begin
        if (acc && last_word) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_rdy_0  = 1'b0;
    o_rdy_1  = 1'b0;
    o_grant  = 2'b00;
    grant_ev = 1'b0;
    hdr_load = 1'b0;
    acc      = 1'b0;
    done_set = 1'b0;
    done_src = src_q;
    case (state_q)
      ST_IDLE: begin
        grant_ev = any_pend;
        done_src = sel;
        // Header-less zero-length packet completes at the grant itself.
        done_set = any_pend && (HDR_EN == 0) && (len_sel == 16'd0);
      end
      ST_HDR: begin
        o_grant  = src_q ? 2'b10 : 2'b01;
        hdr_load = slot_free;
        done_set = slot_free && (len_q == 16'd0);
      end
      ST_DATA: begin
        o_grant  = src_q ? 2'b10 : 2'b01;
        o_rdy_0  = ~src_q & slot_free;
        o_rdy_1  = src_q & slot_free;
        acc      = src_vld & slot_free;
        done_set = acc & last_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= 16'd0;
      src_q  <= 1'b0;
      cnt_q  <= 16'd0;
      last_q <= 1'b1;
    end else if (grant_ev) begin
      len_q  <= len_sel;
      src_q  <= sel;
      cnt_q  <= 16'd0;
      last_q <= sel;
    end else if (acc) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= 32'd0;
      out_vld_q  <= 1'b0;
      done_q     <= 2'b00;
    end else begin
      if (hdr_load) begin
        out_data_q <= {HDR_TAG, 7'd0, src_q, len_q};
        out_vld_q  <= 1'b1;
      end else if (acc) begin
        out_data_q <= src_data;
        out_vld_q  <= 1'b1;
      end else if (slot_free) begin
        out_vld_q <= 1'b0;
      end
      done_q <= done_set ? (done_src ? 2'b10 : 2'b01) : 2'b00;
    end
  end

  assign o_out_data = out_data_q;
  assign o_out_vld  = out_vld_q;
  assign o_done_0   = done_q[0];
  assign o_done_1   = done_q[1];
  assign o_busy     = (state_q != ST_IDLE);

`ifndef SYNTHESIS
  a_rdy_excl: assert property (@(posedge sys_clk) disable iff (!rst_n) !(o_rdy_0 && o_rdy_1));
  a_hold: assert property (@(posedge sys_clk) disable iff (!rst_n)
    (out_vld_q && !i_out_rdy) |=> (out_vld_q && $stable(out_data_q)));
  a_cnt_bound: assert property (@(posedge sys_clk) disable iff (!rst_n)
    (state_q == ST_DATA) |-> (cnt_q < len_q));
`endif

endmodule

// File: tb/tb_frame_out_arbiter.sv
// Scoreboard bench: directed packets push hand-computed words into a queue; a negedge monitor pops and compares on each output handshake.
module tb_frame_out_arbiter;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        i_pend_0 = 1'b0, i_pend_1 = 1'b0;
  logic [15:0] i_len_0 = 16'd0, i_len_1 = 16'd0;
  logic [31:0] i_data_0 = 32'd0, i_data_1 = 32'd0;
  logic        i_vld_0 = 1'b0, i_vld_1 = 1'b0;
  logic        i_out_rdy = 1'b1;
  logic        o_rdy_0, o_rdy_1, o_done_0, o_done_1, o_out_vld, o_busy;
  logic [31:0] o_out_data;
  logic [1:0]  o_grant;

  logic        n_pend_0 = 1'b0, n_pend_1 = 1'b0;
  logic [15:0] n_len_0 = 16'd0, n_len_1 = 16'd0;
  logic [31:0] n_data_0 = 32'd0, n_data_1 = 32'd0;
  logic        n_vld_0 = 1'b0, n_vld_1 = 1'b0;
  logic        n_out_rdy = 1'b1;
  logic        n_rdy_0, n_rdy_1, n_done_0, n_done_1, n_out_vld, n_busy;
  logic [31:0] n_out_data;
  logic [1:0]  n_grant;

  frame_out_arbiter u_dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .i_pend_0(i_pend_0), .i_pend_1(i_pend_1), .i_len_0(i_len_0), .i_len_1(i_len_1),
    .i_data_0(i_data_0), .i_data_1(i_data_1), .i_vld_0(i_vld_0), .i_vld_1(i_vld_1),
    .o_rdy_0(o_rdy_0), .o_rdy_1(o_rdy_1), .o_done_0(o_done_0), .o_done_1(o_done_1),
    .o_out_data(o_out_data), .o_out_vld(o_out_vld), .i_out_rdy(i_out_rdy),
    .o_grant(o_grant), .o_busy(o_busy)
  );

  frame_out_arbiter #(.HDR_EN(0)) u_dut_nh (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .i_pend_0(n_pend_0), .i_pend_1(n_pend_1), .i_len_0(n_len_0), .i_len_1(n_len_1),
    .i_data_0(n_data_0), .i_data_1(n_data_1), .i_vld_0(n_vld_0), .i_vld_1(n_vld_1),
    .o_rdy_0(n_rdy_0), .o_rdy_1(n_rdy_1), .o_done_0(n_done_0), .o_done_1(n_done_1),
    .o_out_data(n_out_data), .o_out_vld(n_out_vld), .i_out_rdy(n_out_rdy),
    .o_grant(n_grant), .o_busy(n_busy)
  );

  typedef struct packed {logic [31:0] d; logic d0; logic d1;} exp_t;
  exp_t        expq[$];
  logic [15:0] plen0[$], plen1[$];
  logic [31:0] wq0[$], wq1[$];

  int checks = 0, passed = 0;
  int cyc = 0;
  int pend_rise_cyc = 0, first_vld_cyc = -1;
  int nacc = 0, dcnt0 = 0, dcnt1 = 0;
  int acc_cyc[$];
  bit stall1_en = 1'b0, bp_en = 1'b0;
  logic acc0 = 1'b0, acc1 = 1'b0, gnew0 = 1'b0, gnew1 = 1'b0, g0_prev = 1'b0, g1_prev = 1'b0;
  logic pend_prev0 = 1'b0;

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Source model: one packet per queued length, words presented in order, pend dropped once granted.
  always @(posedge sys_clk) begin
    #1;
    if (acc0 && wq0.size() > 0) wq0.delete(0);
    if (acc1 && wq1.size() > 0) wq1.delete(0);
    if (gnew0 && plen0.size() > 0) plen0.delete(0);
    if (gnew1 && plen1.size() > 0) plen1.delete(0);
    pend_prev0 = i_pend_0;
    i_pend_0 = (plen0.size() > 0);
    i_len_0  = (plen0.size() > 0) ? plen0[0] : 16'd0;
    if (i_pend_0 && !pend_prev0) pend_rise_cyc = cyc;
    i_pend_1 = (plen1.size() > 0);
    i_len_1  = (plen1.size() > 0) ? plen1[0] : 16'd0;
    i_vld_0  = (wq0.size() > 0);
    i_data_0 = (wq0.size() > 0) ? wq0[0] : 32'd0;
    i_vld_1  = (wq1.size() > 0) && !(stall1_en && (cyc % 3 != 0));
    i_data_1 = (wq1.size() > 0) ? wq1[0] : 32'd0;
    i_out_rdy = bp_en ? (cyc % 3 == 0) : 1'b1;
  end

  logic        prev_vld = 1'b0, prev_rdy = 1'b0, cur_d0 = 1'b0, cur_d1 = 1'b0, mon_new;
  logic [31:0] prev_data = 32'd0;
  exp_t        mon_e;

  always @(negedge sys_clk) begin
    if (!rst_n) begin
      prev_vld = 1'b0; prev_rdy = 1'b0;
      acc0 = 1'b0; acc1 = 1'b0; gnew0 = 1'b0; gnew1 = 1'b0; g0_prev = 1'b0; g1_prev = 1'b0;
    end else begin
      acc0 = i_vld_0 & o_rdy_0;
      acc1 = i_vld_1 & o_rdy_1;
      gnew0 = o_grant[0] & ~g0_prev; g0_prev = o_grant[0];
      gnew1 = o_grant[1] & ~g1_prev; g1_prev = o_grant[1];
      if (o_done_0) dcnt0++;
      if (o_done_1) dcnt1++;
      if (prev_vld && !prev_rdy)
        chk("hold", o_out_vld && (o_out_data == prev_data), 64'({o_out_vld, o_out_data}), 64'({1'b1, prev_data}));
      mon_new = o_out_vld && (!prev_vld || prev_rdy);
      if (mon_new) begin
        cur_d0 = o_done_0; cur_d1 = o_done_1;
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
      end else begin
        chk("done_stray", !(o_done_0 || o_done_1), 64'({o_done_1, o_done_0}), 64'd0);
      end
      if (o_out_vld && !i_out_rdy)
        chk("rdy_blocked", !(o_rdy_0 || o_rdy_1), 64'({o_rdy_1, o_rdy_0}), 64'd0);
      if (o_out_vld && i_out_rdy) begin
        if (expq.size() == 0) begin
          chk("unexpected_word", 1'b0, 64'(o_out_data), 64'd0);
        end else begin
          mon_e = expq.pop_front();
          chk("word", {o_out_data, cur_d0, cur_d1} == mon_e, 64'({o_out_data, cur_d0, cur_d1}), 64'(mon_e));
        end
        nacc++;
        acc_cyc.push_back(cyc);
      end
      prev_vld = o_out_vld; prev_rdy = i_out_rdy; prev_data = o_out_data;
    end
  end

  task automatic exp_pkt(input logic [31:0] hdr, input bit src, input int len, input logic [31:0] base);
    exp_t e;
    e.d = hdr; e.d0 = (len == 0) && !src; e.d1 = (len == 0) && src;
    expq.push_back(e);
    for (int i = 0; i < len; i++) begin
      e.d  = base + 32'(i);
      e.d0 = (i == len - 1) && !src;
      e.d1 = (i == len - 1) && src;
      expq.push_back(e);
    end
  endtask

  task automatic src_pkt(input bit src, input int len, input logic [31:0] base);
    if (src) plen1.push_back(16'(len)); else plen0.push_back(16'(len));
    for (int i = 0; i < len; i++) begin
      if (src) wq1.push_back(base + 32'(i)); else wq0.push_back(base + 32'(i));
    end
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while ((expq.size() != 0 || plen0.size() != 0 || plen1.size() != 0 || o_busy) && n < max) begin
      @(negedge sys_clk); #1;
      n++;
    end
    chk("drain_timeout", n < max, 64'(n), 64'(max));
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    expq.delete(); plen0.delete(); plen1.delete(); wq0.delete(); wq1.delete();
    repeat (2) @(negedge sys_clk);
    #2 rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  initial begin
    int base, n, dsave;
    repeat (3) @(negedge sys_clk);
    chk("rst_out_vld",  o_out_vld == 1'b0,   64'(o_out_vld), 64'd0);
    chk("rst_out_data", o_out_data == 32'd0, 64'(o_out_data), 64'd0);
    chk("rst_rdy",      {o_rdy_1, o_rdy_0} == 2'b00, 64'({o_rdy_1, o_rdy_0}), 64'd0);
    chk("rst_done",     {o_done_1, o_done_0} == 2'b00, 64'({o_done_1, o_done_0}), 64'd0);
    chk("rst_grant",    o_grant == 2'b00, 64'(o_grant), 64'd0);
    chk("rst_busy",     o_busy == 1'b0, 64'(o_busy), 64'd0);
    #2 rst_n = 1'b1;
    @(negedge sys_clk);

    // Single packet, source 0, len 3
    base = acc_cyc.size();
    exp_pkt(32'hA500_0003, 1'b0, 3, 32'd1);
    src_pkt(1'b0, 3, 32'd1);
    @(negedge sys_clk);
    chk("idle_grant", o_grant == 2'b00 && !o_busy, 64'({o_busy, o_grant}), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge sys_clk);
      chk("pkt_grant", o_grant == 2'b01 && o_busy, 64'({o_busy, o_grant}), 64'h5);
    end
    @(negedge sys_clk);
    chk("end_grant", o_grant == 2'b00, 64'(o_grant), 64'd0);
    wait_drain(100);
    chk("latency", first_vld_cyc - pend_rise_cyc == 2, 64'(first_vld_cyc - pend_rise_cyc), 64'd2);
    chk("span_single", acc_cyc[base+3] - acc_cyc[base] == 3, 64'(acc_cyc[base+3] - acc_cyc[base]), 64'd3);

    // Contention from reset: grants 0,1,0,1,0 with one bubble between packets
    do_reset();
    base = acc_cyc.size();
    exp_pkt(32'hA500_0002, 1'b0, 2, 32'h100);
    exp_pkt(32'hA501_0002, 1'b1, 2, 32'h200);
    exp_pkt(32'hA500_0002, 1'b0, 2, 32'h110);
    exp_pkt(32'hA501_0002, 1'b1, 2, 32'h210);
    exp_pkt(32'hA500_0002, 1'b0, 2, 32'h120);
    src_pkt(1'b0, 2, 32'h100); src_pkt(1'b0, 2, 32'h110); src_pkt(1'b0, 2, 32'h120);
    src_pkt(1'b1, 2, 32'h200); src_pkt(1'b1, 2, 32'h210);
    wait_drain(300);
    chk("span_contention", acc_cyc.size() == base + 15 && acc_cyc[base+14] - acc_cyc[base] == 18,
        64'(acc_cyc[acc_cyc.size()-1] - acc_cyc[base]), 64'd18);

    // Backpressure: downstream ready 1,0,0 repeating
    bp_en = 1'b1;
    exp_pkt(32'hA500_0004, 1'b0, 4, 32'h31);
    src_pkt(1'b0, 4, 32'h31);
    wait_drain(300);
    bp_en = 1'b0;
    repeat (2) @(negedge sys_clk);

    // Zero length with header
    exp_pkt(32'hA500_0000, 1'b0, 0, 32'd0);
    src_pkt(1'b0, 0, 32'd0);
    wait_drain(100);

    // Source 1 stalls mid-packet while source 0 becomes pending
    stall1_en = 1'b1;
    exp_pkt(32'hA501_0004, 1'b1, 4, 32'h41);
    src_pkt(1'b1, 4, 32'h41);
    n = 0;
    while (o_grant != 2'b10 && n < 20) begin @(negedge sys_clk); n++; end
    chk("stall_grant", o_grant == 2'b10, 64'(o_grant), 64'h2);
    exp_pkt(32'hA500_0002, 1'b0, 2, 32'h4A);
    src_pkt(1'b0, 2, 32'h4A);
    wait_drain(300);
    stall1_en = 1'b0;

    // Reset after two payload words of a five-word packet
    base = nacc;
    dsave = dcnt0;
    exp_pkt(32'hA500_0005, 1'b0, 5, 32'h51);
    src_pkt(1'b0, 5, 32'h51);
    n = 0;
    while (nacc < base + 3 && n < 50) begin @(negedge sys_clk); #1; n++; end
    chk("reset_wait", nacc >= base + 3, 64'(nacc - base), 64'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {o_out_vld, o_out_data, o_rdy_0, o_rdy_1, o_done_0, o_done_1, o_grant, o_busy} == 40'd0,
        64'({o_out_vld, o_out_data, o_rdy_0, o_rdy_1, o_done_0, o_done_1, o_grant, o_busy}), 64'd0);
    expq.delete(); plen0.delete(); plen1.delete(); wq0.delete(); wq1.delete();
    repeat (2) @(negedge sys_clk);
    chk("mid_rst_no_done", dcnt0 == dsave, 64'(dcnt0), 64'(dsave));
    #2 rst_n = 1'b1;
    @(negedge sys_clk);
    exp_pkt(32'hA500_0001, 1'b0, 1, 32'h61);
    src_pkt(1'b0, 1, 32'h61);
    wait_drain(100);
    chk("post_rst_done", dcnt0 == dsave + 1, 64'(dcnt0), 64'(dsave + 1));

    // Header-less instance: zero length, then a two-word packet
    @(posedge sys_clk); #1;
    n_pend_0 = 1'b1; n_len_0 = 16'd0;
    @(negedge sys_clk);
    chk("nh_zero_idle", !n_busy && !n_done_0, 64'({n_busy, n_done_0}), 64'd0);
    @(posedge sys_clk); #1;
    n_pend_0 = 1'b0;
    @(negedge sys_clk);
    chk("nh_zero_done", n_done_0 && !n_out_vld && n_grant == 2'b00, 64'({n_done_0, n_out_vld, n_grant}), 64'h8);
    @(negedge sys_clk);
    chk("nh_zero_pulse", !n_done_0, 64'(n_done_0), 64'd0);
    @(posedge sys_clk); #1;
    n_pend_0 = 1'b1; n_len_0 = 16'd2; n_vld_0 = 1'b1; n_data_0 = 32'h11;
    @(negedge sys_clk);
    chk("nh_rdy_idle", !n_rdy_0, 64'(n_rdy_0), 64'd0);
    @(posedge sys_clk); #1;
    n_pend_0 = 1'b0;
    @(negedge sys_clk);
    chk("nh_rdy_t1", n_rdy_0 && !n_out_vld && n_grant == 2'b01, 64'({n_rdy_0, n_out_vld, n_grant}), 64'h9);
    @(posedge sys_clk); #1;
    n_data_0 = 32'h22;
    @(negedge sys_clk);
    chk("nh_word1", n_out_vld && n_out_data == 32'h11 && !n_done_0, 64'({n_out_vld, n_done_0, n_out_data}), 64'h2_0000_0011);
    @(posedge sys_clk); #1;
    n_vld_0 = 1'b0;
    @(negedge sys_clk);
    chk("nh_word2", n_out_vld && n_out_data == 32'h22 && n_done_0, 64'({n_out_vld, n_done_0, n_out_data}), 64'h3_0000_0022);
    @(negedge sys_clk);
    chk("nh_drain", !n_out_vld && !n_busy, 64'({n_out_vld, n_busy}), 64'd0);

    chk("sb_empty", expq.size() == 0, 64'(expq.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", checks, passed);
    $fatal(1);
  end

endmodule
